// File: rtl/mmio_timer.sv
// Memory-mapped 64-bit timer with a prescaler, a compare-match flag and a registered IRQ.
// Register reads are combinational; writes land on the rising clock edge when all four byte lanes are enabled.
module mmio_timer #(
  parameter logic [63:0] BASE_ADDR = 64'h0000_0000_FF20_0000
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        wReadEnable,
  input  logic        wWriteEnable,
  input  logic [3:0]  wByteEnable,
  input  logic [63:0] wAddress,
  input  logic [63:0] wWriteData,
  output logic [63:0] wReadData,
  output logic        oIRQ
);

  localparam logic [2:0] OFF_CTRL     = 3'd0;
  localparam logic [2:0] OFF_COUNT    = 3'd1;
  localparam logic [2:0] OFF_COMPARE  = 3'd2;
  localparam logic [2:0] OFF_STATUS   = 3'd3;
  localparam logic [2:0] OFF_PRESCALE = 3'd4;

  logic [2:0]  r_ctrl;
  logic [63:0] r_count;
  logic [63:0] r_compare;
  logic        r_match;
  logic [15:0] r_prescale;
  logic [15:0] r_pcnt;
  logic        r_irq;

  logic        w_sel;
  logic [2:0]  w_off;
  logic        w_wr;
  logic        w_wr_ctrl;
  logic        w_wr_count;
  logic        w_wr_compare;
  logic        w_wr_status;
  logic        w_wr_prescale;
  logic        w_tick;
  logic        w_eq;
  logic        w_hit;
  logic [63:0] w_rdata;
  logic        w_unused;

  assign w_sel         = (wAddress[63:6] == BASE_ADDR[63:6]);
  assign w_off         = wAddress[5:3];
  assign w_wr          = w_sel && wWriteEnable && (wByteEnable == 4'b1111);
  assign w_wr_ctrl     = w_wr && (w_off == OFF_CTRL);
  assign w_wr_count    = w_wr && (w_off == OFF_COUNT);
  assign w_wr_compare  = w_wr && (w_off == OFF_COMPARE);
  assign w_wr_status   = w_wr && (w_off == OFF_STATUS);
  assign w_wr_prescale = w_wr && (w_off == OFF_PRESCALE);

  assign w_tick = r_ctrl[0] && (r_pcnt == r_prescale);
  assign w_eq   = (r_count == r_compare);
  // A CPU write to COUNT on a tick edge replaces the count and suppresses that tick's match.
  assign w_hit  = w_tick && w_eq && !w_wr_count;

  assign w_unused = &{1'b0, wAddress[2:0]};

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_ctrl     <= 3'd0;
      r_count    <= 64'd0;
      r_compare  <= 64'd0;
      r_match    <= 1'b0;
      r_prescale <= 16'd0;
      r_pcnt     <= 16'd0;
      r_irq      <= 1'b0;
    end else begin
      if (w_wr_ctrl)     r_ctrl     <= wWriteData[2:0];
      if (w_wr_compare)  r_compare  <= wWriteData;
      if (w_wr_prescale) r_prescale <= wWriteData[15:0];

      if (w_wr_ctrl || w_wr_prescale) begin
        r_pcnt <= 16'd0;
      end else if (r_ctrl[0]) begin
        r_pcnt <= w_tick ? 16'd0 : r_pcnt + 16'd1;
      end

      if (w_wr_count) begin
        r_count <= wWriteData;
      end else if (w_tick) begin
        r_count <= (w_eq && r_ctrl[1]) ? 64'd0 : r_count + 64'd1;
      end

      // Set beats a simultaneous write-1-to-clear.
      if (w_hit) begin
        r_match <= 1'b1;
      end else if (w_wr_status && wWriteData[0]) begin
        r_match <= 1'b0;
      end

      r_irq <= r_match && r_ctrl[2];
    end
  end

  always_comb begin
    w_rdata = 64'd0;
    if (w_sel && wReadEnable) begin
      case (w_off)
        OFF_CTRL:     w_rdata = {61'd0, r_ctrl};
        OFF_COUNT:    w_rdata = r_count;
        OFF_COMPARE:  w_rdata = r_compare;
        OFF_STATUS:   w_rdata = {63'd0, r_match};
        OFF_PRESCALE: w_rdata = {48'd0, r_prescale};
        default:      w_rdata = 64'd0;
      endcase
    end
  end

  assign wReadData = w_rdata;
  assign oIRQ      = r_irq;

endmodule

// File: tb/tb_mmio_timer.sv
// Directed bench for mmio_timer: the driver queues expected read/IRQ values, a negedge monitor pops and compares.
module tb_mmio_timer;

  localparam logic [63:0] BASE = 64'h0000_0000_FF20_0000;

  logic        iCLK;
  logic        iRST;
  logic        wReadEnable;
  logic        wWriteEnable;
  logic [3:0]  wByteEnable;
  logic [63:0] wAddress;
  logic [63:0] wWriteData;
  logic [63:0] wReadData;
  logic        oIRQ;

  mmio_timer #(.BASE_ADDR(BASE)) dut (
    .iCLK        (iCLK),
    .iRST        (iRST),
    .wReadEnable (wReadEnable),
    .wWriteEnable(wWriteEnable),
    .wByteEnable (wByteEnable),
    .wAddress    (wAddress),
    .wWriteData  (wWriteData),
    .wReadData   (wReadData),
    .oIRQ        (oIRQ)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  typedef struct {
    bit          is_irq;
    logic [63:0] val;
    string       name;
  } exp_t;

  exp_t        sb[$];
  int          chk_n = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  exp_t        m_e;
  logic [63:0] m_act;

  // Monitor: pops one expectation per output presented in this cycle.
  always @(negedge iCLK) begin
    for (int i = 0; i < chk_n; i++) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL scoreboard_underflow: output presented with no expectation queued");
      end else begin
        m_e   = sb.pop_front();
        m_act = m_e.is_irq ? {63'd0, oIRQ} : wReadData;
        if (m_act !== m_e.val) begin
          n_bad++;
          $display("FAIL %s: got %h expected %h", m_e.name, m_act, m_e.val);
        end
      end
    end
  end

  function automatic logic [63:0] A(input int off);
    return BASE + 64'(off * 8);
  endfunction

  task automatic wr(input int off, input logic [63:0] d, input logic [3:0] be);
    wAddress     = A(off);
    wWriteData   = d;
    wByteEnable  = be;
    wWriteEnable = 1'b1;
    @(posedge iCLK); #1;
    wWriteEnable = 1'b0;
    wByteEnable  = 4'b0000;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge iCLK); #1;
    end
  endtask

  task automatic probe(input logic [63:0] addr, input logic rden, input logic [63:0] exp_d,
                       input bit chk_irq, input logic exp_irq, input string nm);
    exp_t e;
    int   n;
    wAddress    = addr;
    wReadEnable = rden;
    e.is_irq = 1'b0; e.val = exp_d; e.name = nm;
    sb.push_back(e);
    n = 1;
    if (chk_irq) begin
      e.is_irq = 1'b1; e.val = {63'd0, exp_irq}; e.name = {nm, "_irq"};
      sb.push_back(e);
      n = 2;
    end
    chk_n = n;
    @(posedge iCLK); #1;
    chk_n       = 0;
    wReadEnable = 1'b0;
  endtask

  task automatic rd(input int off, input logic [63:0] exp_d, input string nm);
    probe(A(off), 1'b1, exp_d, 1'b0, 1'b0, nm);
  endtask

  task automatic rdi(input int off, input logic [63:0] exp_d, input logic exp_irq, input string nm);
    probe(A(off), 1'b1, exp_d, 1'b1, exp_irq, nm);
  endtask

  initial begin
    logic [63:0] seq_ar [6];
    logic [63:0] seq_wrap [4];
    seq_ar   = '{64'd0, 64'd1, 64'd2, 64'd3, 64'd0, 64'd1};
    seq_wrap = '{64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd1};

    iRST = 1'b1; wReadEnable = 1'b0; wWriteEnable = 1'b0;
    wByteEnable = 4'b0000; wAddress = 64'd0; wWriteData = 64'd0;
    repeat (2) @(posedge iCLK);
    #1;

    // Reset: writes ignored, reads still live and return zeros.
    wr(1, 64'd5, 4'b1111);
    rdi(1, 64'd0, 1'b0, "rst_count");
    rd(0, 64'd0, "rst_ctrl");
    iRST = 1'b0;
    rd(1, 64'd0, "count_after_rst");
    rd(4, 64'd0, "prescale_rst");

    // Autoreload with compare 3, every-cycle ticks.
    wr(4, 64'd0, 4'b1111);
    wr(2, 64'd3, 4'b1111);
    wr(0, 64'd7, 4'b1111);
    for (int i = 0; i < 6; i++) rdi(1, seq_ar[i], (i == 5), "ar_count");
    rdi(3, 64'd1, 1'b1, "status_set");
    wr(3, 64'd1, 4'b1111);
    rdi(3, 64'd1, 1'b1, "w1c_vs_new_match");
    wr(3, 64'd1, 4'b1111);
    rdi(3, 64'd0, 1'b1, "w1c_irq_lag");
    wr(1, 64'd7, 4'b1111);
    rdi(1, 64'd7, 1'b0, "count_write_wins");
    rdi(3, 64'd0, 1'b0, "match_suppressed");
    wr(0, 64'd0, 4'b1111);
    rd(1, 64'd10, "count_stopped");
    rd(0, 64'd0, "ctrl_off");
    wr(1, 64'd7, 4'b0011);
    rd(1, 64'd10, "partial_be_ignored");
    wr(5, 64'hFFFF_FFFF_FFFF_FFFF, 4'b1111);
    rd(5, 64'd0, "off5_zero");
    wr(0, 64'hF8, 4'b1111);
    rd(0, 64'd0, "ctrl_upper_zero");
    wr(4, 64'hFFFF_FFFF_FFFF_1234, 4'b1111);
    rd(4, 64'h1234, "prescale_upper_zero");

    // Prescale 4: one increment per 5 cycles; rewriting PRESCALE restarts the phase.
    wr(1, 64'd0, 4'b1111);
    wr(2, 64'd100, 4'b1111);
    wr(4, 64'd4, 4'b1111);
    wr(0, 64'd1, 4'b1111);
    idle(49);
    rdi(1, 64'd9, 1'b0, "pre4_49cyc");
    rdi(1, 64'd10, 1'b0, "pre4_50cyc");
    wr(4, 64'd4, 4'b1111);
    idle(4);
    rd(1, 64'd10, "pcnt_cleared");
    rd(1, 64'd11, "tick_after_clear");
    wr(0, 64'd0, 4'b1111);

    // Wrap through all-ones without a match.
    wr(4, 64'd0, 4'b1111);
    wr(2, 64'd5, 4'b1111);
    wr(1, 64'hFFFF_FFFF_FFFF_FFFE, 4'b1111);
    wr(0, 64'd1, 4'b1111);
    for (int i = 0; i < 4; i++) rd(1, seq_wrap[i], "wrap_count");
    rd(3, 64'd0, "wrap_no_match");
    wr(0, 64'd0, 4'b1111);

    // Match without autoreload or IRQEN; COMPARE write keeps MATCH.
    wr(1, 64'd0, 4'b1111);
    wr(2, 64'd0, 4'b1111);
    wr(0, 64'd1, 4'b1111);
    rd(1, 64'd0, "na_count0");
    wr(0, 64'd0, 4'b1111);
    rdi(3, 64'd1, 1'b0, "match_no_irqen");
    wr(2, 64'd50, 4'b1111);
    rd(3, 64'd1, "compare_keeps_match");
    rd(1, 64'd2, "no_autoreload");
    rd(2, 64'd50, "compare_rb");

    // Reset mid-count.
    wr(3, 64'd1, 4'b1111);
    wr(2, 64'd100, 4'b1111);
    wr(1, 64'd40, 4'b1111);
    wr(4, 64'd0, 4'b1111);
    wr(0, 64'd7, 4'b1111);
    idle(2);
    rd(1, 64'd42, "pre_reset_count");
    iRST = 1'b1;
    wr(1, 64'd99, 4'b1111);
    iRST = 1'b0;
    rdi(0, 64'd0, 1'b0, "post_rst_ctrl");
    rd(1, 64'd0, "post_rst_count");
    rd(2, 64'd0, "post_rst_compare");
    rd(3, 64'd0, "post_rst_status");
    rd(4, 64'd0, "post_rst_prescale");
    for (int i = 0; i < 10; i++) rd(1, 64'd0, "count_idle");

    // Unselected addresses and deasserted read strobe return zero.
    wr(1, 64'd9, 4'b1111);
    probe(64'd0, 1'b1, 64'd0, 1'b0, 1'b0, "unsel_zero_addr");
    probe(BASE + 64'd64, 1'b1, 64'd0, 1'b0, 1'b0, "unsel_next_window");
    probe(BASE | 64'h8000_0000_0000_0008, 1'b1, 64'd0, 1'b0, 1'b0, "unsel_high_bit");
    probe(A(1), 1'b0, 64'd0, 1'b0, 1'b0, "no_read_strobe");
    rd(1, 64'd9, "count_rb_9");

    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_leftover: %0d expectations never checked, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
